// File: rtl/key_expansion_if.sv
// Bundles the connection between the AES-128 key schedule and the round datapath:
// key load, round-key requests and the schedule's status and round-key outputs.
interface key_expansion_if;
    logic         key_load;
    logic [127:0] key_in;
    logic         enc;
    logic [3:0]   rk_idx;
    logic         keygen;
    logic         key_ready;
    logic         key_done;
    logic [127:0] roundKey;

    // The datapath side drives key loads and round-key requests.
    modport master (
        output key_load, key_in, enc, rk_idx,
        input  keygen, key_ready, key_done, roundKey
    );

    modport slave (
        input  key_load, key_in, enc, rk_idx,
        output keygen, key_ready, key_done, roundKey
    );
endinterface

// File: rtl/key_expansion.sv
// AES-128 key schedule: expands one round key per clock into an 11-entry table and
// serves round keys through a registered read port in forward or reverse order.
module key_expansion (
    input  logic            clk,
    input  logic            rst,
    key_expansion_if.slave  kx
);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    // Forward AES S-box; entry b is at bits [(255-b)*8 +: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    state_t       state_reg, state_next;
    logic [3:0]   cnt_reg;
    logic [7:0]   rcon_reg;
    logic [127:0] rk_reg [0:10];
    logic         key_ready_reg;
    logic         key_done_reg;
    logic [127:0] round_key_reg;

    logic         load;
    logic         step;
    logic         last_step;
    logic [3:0]   prev_idx;
    logic [3:0]   eff_idx;
    logic         read_ok;
    logic [127:0] prev_key;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_word, sub_word, t_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon_next;

    assign load      = kx.key_load;
    assign step      = (state_reg == EXPAND) && !load;
    assign last_step = step && (cnt_reg == 4'd10);

    // Round-key recurrence from the previous table entry.
    assign prev_idx = (cnt_reg == 4'd0) ? 4'd0 : cnt_reg - 4'd1;
    assign prev_key = rk_reg[prev_idx];
    assign {w0, w1, w2, w3} = prev_key;
    assign rot_word = {w3[23:0], w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub_word
            assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
        end
    endgenerate

    assign t_word    = sub_word ^ {rcon_reg, 24'h000000};
    assign n0        = w0 ^ t_word;
    assign n1        = w1 ^ n0;
    assign n2        = w2 ^ n1;
    assign n3        = w3 ^ n2;
    assign rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

    // Decrypt walks the table backwards; a load in READY blanks the read that same cycle.
    assign eff_idx = kx.enc ? kx.rk_idx : (4'd10 - kx.rk_idx);
    assign read_ok = (state_reg == READY) && (kx.rk_idx <= 4'd10) && !load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = EXPAND;
            EXPAND: begin
                if (load)
                    state_next = EXPAND;
                else if (cnt_reg == 4'd10)
                    state_next = READY;
            end
            READY:   if (load) state_next = EXPAND;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= 4'd0;
            rcon_reg      <= 8'h01;
            key_ready_reg <= 1'b0;
            key_done_reg  <= 1'b0;
            round_key_reg <= 128'd0;
            for (int i = 0; i <= 10; i++) begin
                rk_reg[i] <= 128'd0;
            end
        end else begin
            key_done_reg <= 1'b0;
            if (load) begin
                rk_reg[0]     <= kx.key_in;
                cnt_reg       <= 4'd1;
                rcon_reg      <= 8'h01;
                key_ready_reg <= 1'b0;
            end else if (step) begin
                rk_reg[cnt_reg] <= {n0, n1, n2, n3};
                cnt_reg         <= cnt_reg + 4'd1;
                rcon_reg        <= rcon_next;
                if (last_step) begin
                    key_ready_reg <= 1'b1;
                    key_done_reg  <= 1'b1;
                end
            end
            round_key_reg <= read_ok ? rk_reg[eff_idx] : 128'd0;
        end
    end

    assign kx.keygen    = (state_reg == EXPAND);
    assign kx.key_ready = key_ready_reg;
    assign kx.key_done  = key_done_reg;
    assign kx.roundKey  = round_key_reg;

endmodule

// File: tb/tb_key_expansion.sv
// Directed-vector bench for the AES-128 key schedule using FIPS-197 and all-zero key vectors.
module tb_key_expansion;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    key_expansion_if kx ();

    key_expansion dut (
        .clk (clk),
        .rst (rst),
        .kx  (kx)
    );

    localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK2_FIPS  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_ZERO  = 128'h0;
    localparam logic [127:0] RK1_ZERO  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] RK10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int vectors     = 0;
    int miscompares = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        kx.key_in   = k;
        kx.key_load = 1'b1;
        tick;
        kx.key_load = 1'b0;
    endtask

    task automatic do_read(input logic e, input logic [3:0] idx);
        kx.enc    = e;
        kx.rk_idx = idx;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        kx.key_load = 1'b0;
        kx.key_in   = 128'd0;
        kx.enc      = 1'b1;
        kx.rk_idx   = 4'd0;
        tick;
        tick;
        vectors++;
        if (kx.keygen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_keygen got %b want 0", kx.keygen);
        end
        vectors++;
        if (kx.key_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_key_ready got %b want 0", kx.key_ready);
        end
        vectors++;
        if (kx.key_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_key_done got %b want 0", kx.key_done);
        end
        vectors++;
        if (kx.roundKey !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_roundKey got %h want 0", kx.roundKey);
        end
        rst = 1'b0;
        tick;
        vectors++;
        if (kx.keygen !== 1'b0 || kx.roundKey !== 128'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset got keygen=%b roundKey=%h want 0/0", kx.keygen, kx.roundKey);
        end
        $display("test_reset done");
    endtask

    task automatic test_fips_expansion;
        kx.enc    = 1'b1;
        kx.rk_idx = 4'd0;
        load_key(KEY_FIPS);
        // Observation k is just after edge N+k; any index read during EXPAND returns 0.
        for (int k = 0; k <= 10; k++) begin
            vectors++;
            if (kx.keygen !== logic'(k <= 9)) begin
                miscompares++;
                $display("FAIL fips_keygen k=%0d got %b want %b", k, kx.keygen, logic'(k <= 9));
            end
            vectors++;
            if (kx.key_done !== logic'(k == 10)) begin
                miscompares++;
                $display("FAIL fips_key_done k=%0d got %b want %b", k, kx.key_done, logic'(k == 10));
            end
            vectors++;
            if (kx.roundKey !== 128'd0) begin
                miscompares++;
                $display("FAIL fips_read_during_expand k=%0d got %h want 0", k, kx.roundKey);
            end
            if (k < 10) begin
                kx.rk_idx = 4'(k + 1);
                tick;
            end
        end
        vectors++;
        if (kx.key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fips_key_ready got %b want 1", kx.key_ready);
        end
        do_read(1'b1, 4'd0);
        vectors++;
        if (kx.roundKey !== KEY_FIPS) begin
            miscompares++;
            $display("FAIL fips_rk0 got %h want %h", kx.roundKey, KEY_FIPS);
        end
        vectors++;
        if (kx.key_done !== 1'b0) begin
            miscompares++;
            $display("FAIL fips_key_done_drop got %b want 0", kx.key_done);
        end
        do_read(1'b1, 4'd1);
        vectors++;
        if (kx.roundKey !== RK1_FIPS) begin
            miscompares++;
            $display("FAIL fips_rk1 got %h want %h", kx.roundKey, RK1_FIPS);
        end
        do_read(1'b1, 4'd2);
        vectors++;
        if (kx.roundKey !== RK2_FIPS) begin
            miscompares++;
            $display("FAIL fips_rk2 got %h want %h", kx.roundKey, RK2_FIPS);
        end
        do_read(1'b1, 4'd10);
        vectors++;
        if (kx.roundKey !== RK10_FIPS) begin
            miscompares++;
            $display("FAIL fips_rk10 got %h want %h", kx.roundKey, RK10_FIPS);
        end
        $display("test_fips_expansion done");
    endtask

    task automatic test_reverse;
        do_read(1'b0, 4'd0);
        vectors++;
        if (kx.roundKey !== RK10_FIPS) begin
            miscompares++;
            $display("FAIL reverse_idx0 got %h want %h", kx.roundKey, RK10_FIPS);
        end
        do_read(1'b0, 4'd9);
        vectors++;
        if (kx.roundKey !== RK1_FIPS) begin
            miscompares++;
            $display("FAIL reverse_idx9 got %h want %h", kx.roundKey, RK1_FIPS);
        end
        do_read(1'b0, 4'd10);
        vectors++;
        if (kx.roundKey !== KEY_FIPS) begin
            miscompares++;
            $display("FAIL reverse_idx10 got %h want %h", kx.roundKey, KEY_FIPS);
        end
        $display("test_reverse done");
    endtask

    task automatic test_boundary;
        do_read(1'b1, 4'd11);
        vectors++;
        if (kx.roundKey !== 128'd0) begin
            miscompares++;
            $display("FAIL boundary_fwd_idx11 got %h want 0", kx.roundKey);
        end
        do_read(1'b1, 4'd15);
        vectors++;
        if (kx.roundKey !== 128'd0) begin
            miscompares++;
            $display("FAIL boundary_fwd_idx15 got %h want 0", kx.roundKey);
        end
        do_read(1'b0, 4'd11);
        vectors++;
        if (kx.roundKey !== 128'd0) begin
            miscompares++;
            $display("FAIL boundary_rev_idx11 got %h want 0", kx.roundKey);
        end
        $display("test_boundary done");
    endtask

    task automatic test_restart;
        kx.enc    = 1'b1;
        kx.rk_idx = 4'd0;
        load_key(KEY_FIPS);
        tick;
        tick;
        tick;
        load_key(KEY_ZERO);
        for (int k = 0; k <= 10; k++) begin
            vectors++;
            if (kx.keygen !== logic'(k <= 9)) begin
                miscompares++;
                $display("FAIL restart_keygen k=%0d got %b want %b", k, kx.keygen, logic'(k <= 9));
            end
            vectors++;
            if (kx.key_done !== logic'(k == 10) || kx.key_ready !== logic'(k == 10)) begin
                miscompares++;
                $display("FAIL restart_done_ready k=%0d got %b/%b want %b", k, kx.key_done, kx.key_ready, logic'(k == 10));
            end
            if (k < 10) tick;
        end
        do_read(1'b1, 4'd1);
        vectors++;
        if (kx.roundKey !== RK1_ZERO) begin
            miscompares++;
            $display("FAIL restart_rk1 got %h want %h", kx.roundKey, RK1_ZERO);
        end
        do_read(1'b1, 4'd10);
        vectors++;
        if (kx.roundKey !== RK10_ZERO) begin
            miscompares++;
            $display("FAIL restart_rk10 got %h want %h", kx.roundKey, RK10_ZERO);
        end
        $display("test_restart done");
    endtask

    task automatic test_load_in_ready;
        kx.enc    = 1'b1;
        kx.rk_idx = 4'd1;
        load_key(KEY_FIPS);
        vectors++;
        if (kx.roundKey !== 128'd0 || kx.key_ready !== 1'b0 || kx.keygen !== 1'b1) begin
            miscompares++;
            $display("FAIL load_in_ready got roundKey=%h ready=%b keygen=%b want 0/0/1", kx.roundKey, kx.key_ready, kx.keygen);
        end
        for (int k = 1; k <= 10; k++) tick;
        do_read(1'b1, 4'd1);
        vectors++;
        if (kx.roundKey !== RK1_FIPS) begin
            miscompares++;
            $display("FAIL reload_rk1 got %h want %h", kx.roundKey, RK1_FIPS);
        end
        $display("test_load_in_ready done");
    endtask

    task automatic test_reset_mid_expansion;
        kx.enc    = 1'b1;
        kx.rk_idx = 4'd0;
        load_key(KEY_FIPS);
        tick;
        tick;
        rst = 1'b1;
        tick;
        tick;
        vectors++;
        if (kx.keygen !== 1'b0 || kx.key_ready !== 1'b0 || kx.key_done !== 1'b0 || kx.roundKey !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_mid got keygen=%b ready=%b done=%b roundKey=%h want all 0", kx.keygen, kx.key_ready, kx.key_done, kx.roundKey);
        end
        rst = 1'b0;
        tick;
        vectors++;
        if (kx.keygen !== 1'b0 || kx.roundKey !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_mid_idle got keygen=%b roundKey=%h want 0/0", kx.keygen, kx.roundKey);
        end
        $display("test_reset_mid_expansion done");
    endtask

    task automatic test_rst_and_load;
        kx.enc    = 1'b1;
        kx.rk_idx = 4'd0;
        load_key(KEY_FIPS);
        for (int k = 1; k <= 10; k++) tick;
        vectors++;
        if (kx.key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_load_precond got ready=%b want 1", kx.key_ready);
        end
        rst         = 1'b1;
        kx.key_in   = KEY_ZERO;
        kx.key_load = 1'b1;
        tick;
        rst         = 1'b0;
        kx.key_load = 1'b0;
        vectors++;
        if (kx.keygen !== 1'b0 || kx.key_ready !== 1'b0 || kx.key_done !== 1'b0 || kx.roundKey !== 128'd0) begin
            miscompares++;
            $display("FAIL rst_wins got keygen=%b ready=%b done=%b roundKey=%h want all 0", kx.keygen, kx.key_ready, kx.key_done, kx.roundKey);
        end
        tick;
        vectors++;
        if (kx.keygen !== 1'b0 || kx.key_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wins_idle got keygen=%b ready=%b want 0/0", kx.keygen, kx.key_ready);
        end
        $display("test_rst_and_load done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_fips_expansion;
        test_reverse;
        test_boundary;
        test_restart;
        test_load_in_ready;
        test_reset_mid_expansion;
        test_rst_and_load;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_expansion.md
# key_expansion

AES-128 key schedule for the iterative round datapath. Expands a loaded 128-bit cipher key into the 11 round keys, one per clock, and stores them in an internal key table. Serves the round datapath's `roundKey` input through a registered read port in forward (encrypt) or reverse (decrypt) order. Drives the datapath's `keygen` qualifier while expansion is in progress.

## Interface
- No parameters. AES-128 only; Nk=4, Nr=10, fixed.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_load`  in  1  single-cycle pulse; samples `key_in` and starts expansion.
- `key_in`  in  128  cipher key; bits[127:96] = w0, bits[31:0] = w3.
- `enc`  in  1  1 = forward read order, 0 = reverse (decrypt) read order.
- `rk_idx`  in  4  round index requested by the datapath, 0..10.
- `keygen`  out  1  high while expansion is in progress.
- `key_ready`  out  1  high when all 11 round keys are valid.
- `key_done`  out  1  one-cycle pulse when expansion completes.
- `roundKey`  out  128  registered round key for `rk_idx`.

## Operation
- Key table: 11 x 128-bit registers `rk[0..10]`.
- Round counter `cnt`: 4 bits.
- Rcon register: 8 bits, sequence 01,02,04,08,10,20,40,80,1b,36, advanced by xtime with 0x1b reduction.
- FSM states: IDLE, EXPAND, READY.
  - IDLE → EXPAND on `key_load`.
  - EXPAND → READY after writing `rk[10]`.
  - READY → EXPAND on `key_load`.
  - Any state → IDLE on `rst`.
- On `key_load`:
  - `rk[0]` ← `key_in`.
  - `cnt` ← 1, Rcon ← 01.
  - State ← EXPAND.
  - `key_ready` ← 0.
- Each EXPAND cycle computes `rk[cnt]` from `rk[cnt-1]` = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - Then `cnt`+1 and Rcon advances.
  - Implementation: 4 combinational forward S-box byte lookups, the same S-box function as the round datapath.
- When `cnt`=10 is written: state → READY, `key_ready` ← 1, `key_done` pulses.
- Read port: effective index e = `enc` ? `rk_idx` : 10−`rk_idx`.
  - `roundKey` ← `rk[e]` when state = READY and `rk_idx` ≤ 10.
  - Otherwise `roundKey` ← 0.
- `keygen` = (state == EXPAND). Combinational from the state register.
- `key_load` asserted during EXPAND aborts the run and restarts from the new key. The old `rk[1..10]` are invalid until the new `key_done`.
- The key table is write-only from the FSM. Reads never alter state.

## Timing
- Reset values:
  - State IDLE, `cnt`=0, Rcon=01.
  - All `rk[i]`=0.
  - `keygen`=0, `key_ready`=0, `key_done`=0, `roundKey`=0.
- `rst` has priority over `key_load` in the same cycle.
- Expansion sequence, with `key_load` sampled at edge N:
  - `rk[0]` valid after edge N.
  - `rk[i]` written at edge N+i.
  - `keygen` high for cycles N..N+9 (10 cycles).
  - `key_ready` and `key_done` high after edge N+10. `key_done` drops after edge N+11.
- Read latency: `rk_idx`/`enc` sampled at edge M produce `roundKey` after edge M.
  - The datapath presents index r one cycle before it needs `rk[r]`.
- The first valid read is the sample at edge N+11. The sample at edge N+10 still sees state EXPAND and returns 0.
- Reset mid-expansion: next cycle is IDLE, all outputs are 0, and the partial table is cleared.
- `key_load` during READY: `key_ready` falls after that edge. `roundKey` returns 0 starting with the sample at that edge.

## Test plan
- Reset: assert `rst` 2 cycles mid-expansion → all outputs 0, `keygen`=0, state IDLE.
- FIPS-197 expansion: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `enc`=1, after `key_done`:
  - `rk_idx`=0 → `roundKey` = the key.
  - `rk_idx`=1 → a0fafe1788542cb123a339392a6c7605.
  - `rk_idx`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `keygen` high exactly 10 cycles; `key_done` one cycle at N+10.
- Reverse order: same key, `enc`=0, `rk_idx`=0 → d014f9a8c9ee2589e13f0cc8b6630ca6; `rk_idx`=10 → 2b7e151628aed2a6abf7158809cf4f3c.
- Boundary reads:
  - `rk_idx`=11 and `rk_idx`=15 → 0 in READY.
  - Any `rk_idx` during EXPAND → 0.
- Restart: `key_load` with key 000…0 at cycle N+4 of a running expansion → `keygen` continues 10 more cycles. Then `rk_idx`=1 → 62636363626363636263636362636363 and `rk_idx`=10 → b4ef5bcb3e92e21123e951cf6f8f188e.
- Simultaneous `rst` and `key_load` → reset wins, state IDLE, `key_ready`=0.
